dct2d_8x8: RTL and testbench

//  Streaming 8x8 two-dimensional DCT/IDCT engine in 32-bit fixed point.
//  - Loads one 64-sample block (row-major, one sample per clk).
//  - Runs a row pass, then a column pass (separable 8-point 1-D transform).
//  - Streams 64 results out. MODE selects forward DCT or inverse DCT.
//  - A forward instance's done/dout chain directly into an inverse instance's start/din.

---
 rtl/dct_pkg.sv | 46 ++++
 rtl/dct_mac8.sv | 37 +++
 rtl/dct2d_8x8.sv | 164 ++++++++++++++++
 tb/tb_dct2d_8x8.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared types and constants for the 8x8 DCT engine: FSM encoding, MAC operand bundle, Q2.14 cosine table.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dct_pkg;

  localparam int N         = 8;
  localparam int BLK       = 64;
  localparam int ACC_W     = 48;
  localparam int COEF_FRAC = 14;

  typedef enum logic [4:0] {
    ST_IDLE = 5'd0,
    ST_LOAD = 5'd1,
    ST_ROW  = 5'd2,
    ST_COL  = 5'd3,
    ST_OUT  = 5'd4
  } state_t;

  typedef logic signed [15:0] coef_t;

  typedef struct packed {
    logic               first;
    logic               last;
    coef_t              coef;
    logic signed [31:0] smp;
  } mac_op_t;

  // Row u, column x: c(u)/2 * cos((2x+1)u*pi/16) in Q2.14; every row u>0 sums to exactly zero.
  localparam coef_t COS_TBL [BLK] = '{
     16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,  16'sd5793,
     16'sd8035,  16'sd6811,  16'sd4551,  16'sd1598, -16'sd1598, -16'sd4551, -16'sd6811, -16'sd8035,
     16'sd7568,  16'sd3135, -16'sd3135, -16'sd7568, -16'sd7568, -16'sd3135,  16'sd3135,  16'sd7568,
     16'sd6811, -16'sd1598, -16'sd8035, -16'sd4551,  16'sd4551,  16'sd8035,  16'sd1598, -16'sd6811,
     16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,  16'sd5793, -16'sd5793, -16'sd5793,  16'sd5793,
     16'sd4551, -16'sd8035,  16'sd1598,  16'sd6811, -16'sd6811, -16'sd1598,  16'sd8035, -16'sd4551,
     16'sd3135, -16'sd7568,  16'sd7568, -16'sd3135, -16'sd3135,  16'sd7568, -16'sd7568,  16'sd3135,
     16'sd1598, -16'sd4551,  16'sd6811, -16'sd8035,  16'sd8035, -16'sd6811,  16'sd4551, -16'sd1598
  };

  function automatic logic signed [31:0] sat32(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1:31] == {(ACC_W-31){v[31]}}) return v[31:0];
    else if (v[ACC_W-1])                      return 32'h8000_0000;
    else                                      return 32'h7FFF_FFFF;
  endfunction

endpackage

// File: rtl/dct_mac8.sv
// Sequential 8-term multiply-accumulate with >>>14 shift and 32-bit saturation; DCT_ROUND_EN adds a half-LSB before the shift.
// Latency: result is combinational in the cycle of the last term; the accumulator updates every enabled clk.
// Backpressure: none; one term is consumed on every enabled clk.
module dct_mac8 import dct_pkg::*; (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  mac_op_t            i_op,
  output logic               o_res_vld,
  output logic signed [31:0] o_res
);

`ifdef DCT_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEF_FRAC - 1);
`else
  localparam logic signed [ACC_W-1:0] RND = '0;
`endif

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shr;

  assign w_prod = ACC_W'($signed(i_op.coef)) * ACC_W'($signed(i_op.smp));
  // The first term restarts the sum so no separate clear cycle is needed between outputs.
  assign w_sum  = (i_op.first ? {ACC_W{1'b0}} : r_acc) + w_prod;
  assign w_shr  = (w_sum + RND) >>> COEF_FRAC;

  assign o_res     = sat32(w_shr);
  assign o_res_vld = i_en & i_op.last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_acc <= '0;
    else if (i_en) r_acc <= w_sum;
  end

endmodule

// File: rtl/dct2d_8x8.sv
// 8x8 streaming 2-D DCT (MODE=0) / IDCT (MODE=1): load 64, row pass, column pass, stream 64; DCT_ROUND_EN rounds every shift.
// Latency: first done 1025 clk after the last sample edge; a new block may load the cycle after the 64th output.
// Backpressure: none; start only gates entry into LOAD, an accepted block always runs to completion.
module dct2d_8x8 import dct_pkg::*; #(
  parameter int MODE     = 0,
  parameter int IN_FRAC  = 0,
  parameter int OUT_FRAC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] din,
  output logic               reading,
  output logic               done,
  output logic signed [31:0] dout,
  output logic [4:0]         state_out
);

  localparam int ISH = 16 - IN_FRAC;
  localparam int OSH = 16 - OUT_FRAC;
`ifdef DCT_ROUND_EN
  localparam logic signed [32:0] ORND = 33'((1 << OSH) >> 1);
`else
  localparam logic signed [32:0] ORND = '0;
`endif
  localparam logic [8:0] PASS_LAST = 9'(BLK * N - 1);
  localparam logic [8:0] BLK_LAST  = 9'(BLK - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [8:0]         r_cnt;
  logic [8:0]         w_cnt_nxt;
  logic signed [31:0] r_ibuf [BLK];
  logic signed [31:0] r_tbuf [BLK];
  logic signed [31:0] r_dout;

  logic               w_reading;
  logic signed [31:0] w_din_q;
  logic [2:0]         w_a;
  logic [2:0]         w_b;
  logic [2:0]         w_c;
  logic               w_mac_en;
  mac_op_t            w_op;
  logic               w_res_vld;
  logic signed [31:0] w_res;
  logic [5:0]         w_out_idx;
  logic signed [32:0] w_out_ext;
  logic               w_dout_ld;
  logic signed [31:0] w_dout_nxt;

  // Gated by reset so the port reads low while reset is held even if start is high.
  assign w_reading = reset & (((r_state == ST_IDLE) & start) | (r_state == ST_LOAD));
  assign w_din_q   = din <<< ISH;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_cnt_nxt   = 9'd1;
        end
      end
      ST_LOAD: begin
        if (r_cnt == BLK_LAST) begin
          w_state_nxt = ST_ROW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      ST_ROW: begin
        if (r_cnt == PASS_LAST) begin
          w_state_nxt = ST_COL;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      ST_COL: begin
        if (r_cnt == PASS_LAST) begin
          w_state_nxt = ST_OUT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      ST_OUT: begin
        if (r_cnt == BLK_LAST) begin
          w_state_nxt = start ? ST_LOAD : ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 9'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pass counter fields: a = row (ROW) or column u (COL), b = output frequency, c = tap.
  assign w_a      = r_cnt[8:6];
  assign w_b      = r_cnt[5:3];
  assign w_c      = r_cnt[2:0];
  assign w_mac_en = (r_state == ST_ROW) || (r_state == ST_COL);

  always_comb begin
    w_op       = '0;
    w_op.first = (w_c == 3'd0);
    w_op.last  = (w_c == 3'(N - 1));
    w_op.coef  = (MODE == 0) ? COS_TBL[{w_b, w_c}] : COS_TBL[{w_c, w_b}];
    w_op.smp   = (r_state == ST_ROW) ? r_ibuf[{w_a, w_c}] : r_tbuf[{w_c, w_a}];
  end

  dct_mac8 u_mac (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_en      (w_mac_en),
    .i_op      (w_op),
    .o_res_vld (w_res_vld),
    .o_res     (w_res)
  );

  // The input buffer is free once the row pass ends, so the column pass parks Z there row-major.
  always_ff @(posedge clk) begin
    if (w_reading)
      r_ibuf[r_cnt[5:0]] <= w_din_q;
    else if (w_res_vld && (r_state == ST_COL))
      r_ibuf[{w_b, w_a}] <= w_res;
    if (w_res_vld && (r_state == ST_ROW))
      r_tbuf[{w_a, w_b}] <= w_res;
  end

  assign w_out_idx  = (r_state == ST_OUT) ? (r_cnt[5:0] + 6'd1) : 6'd0;
  assign w_out_ext  = 33'(r_ibuf[w_out_idx]) + ORND;
  assign w_dout_nxt = 32'(w_out_ext >>> OSH);
  // Prefetch: DC is registered on the last COL edge so dout is valid in the first done cycle.
  assign w_dout_ld  = ((r_state == ST_COL) && (r_cnt == PASS_LAST)) ||
                      ((r_state == ST_OUT) && (r_cnt != BLK_LAST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_dout <= '0;
    else if (w_dout_ld) r_dout <= w_dout_nxt;
  end

  assign reading   = w_reading;
  assign done      = (r_state == ST_OUT);
  assign dout      = r_dout;
  assign state_out = r_state;

endmodule

// File: tb/tb_dct2d_8x8.sv
// Directed bench for dct2d_8x8: forward, inverse, forward->inverse chain, back-to-back, mid-block reset, saturation.
module tb_dct2d_8x8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_f = 1'b0, start_i_tb = 1'b0, start_s = 1'b0, chain = 1'b0;
  logic [31:0] din_f = '0, din_i_tb = '0;
  logic [31:0] din_s = 32'h7FFF_FFFF;
  logic        reading_f, reading_i, reading_s, done_f, done_i, done_s;
  logic [31:0] dout_f, dout_i, dout_s;
  logic [4:0]  st_f, st_i, st_s;
  logic        w_start_i;
  logic [31:0] w_din_i;

  assign w_start_i = chain ? done_f : start_i_tb;
  assign w_din_i   = chain ? {{16{dout_f[31]}}, dout_f[31:16]} : din_i_tb;

  dct2d_8x8 #(.MODE(0), .IN_FRAC(0), .OUT_FRAC(16)) u_fwd (
    .clk(clk), .reset(rst_n), .start(start_f), .din(din_f), .reading(reading_f),
    .done(done_f), .dout(dout_f), .state_out(st_f));
  dct2d_8x8 #(.MODE(1), .IN_FRAC(0), .OUT_FRAC(10)) u_inv (
    .clk(clk), .reset(rst_n), .start(w_start_i), .din(w_din_i), .reading(reading_i),
    .done(done_i), .dout(dout_i), .state_out(st_i));
  dct2d_8x8 #(.MODE(0), .IN_FRAC(16), .OUT_FRAC(16)) u_sat (
    .clk(clk), .reset(rst_n), .start(start_s), .din(din_s), .reading(reading_s),
    .done(done_s), .dout(dout_s), .state_out(st_s));

  int          errors = 0, checks = 0, cyc = 0;
  logic [31:0] src_f [128];
  logic [31:0] src_i [64];
  logic [31:0] out_f [128];
  logic [31:0] out_i [64];
  logic [31:0] out_s0 = '0;
  int          read_cyc_f [128];
  int          done_cyc_f [128];
  int          ptr_f = 0, ptr_i = 0, ocnt_f = 0, ocnt_i = 0, ocnt_s = 0;

  // Feed samples and capture results half a cycle away from the active edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reading_f) begin
      if (ptr_f < 128) begin
        din_f = src_f[ptr_f];
        read_cyc_f[ptr_f] = cyc;
      end
      ptr_f = ptr_f + 1;
    end
    if (reading_i && !chain) begin
      if (ptr_i < 64) din_i_tb = src_i[ptr_i];
      ptr_i = ptr_i + 1;
    end
    if (done_f) begin
      if (ocnt_f < 128) begin
        out_f[ocnt_f] = dout_f;
        done_cyc_f[ocnt_f] = cyc;
      end
      ocnt_f = ocnt_f + 1;
    end
    if (done_i) begin
      if (ocnt_i < 64) out_i[ocnt_i] = dout_i;
      ocnt_i = ocnt_i + 1;
    end
    if (done_s) begin
      if (ocnt_s == 0) out_s0 = dout_s;
      ocnt_s = ocnt_s + 1;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
    checks = checks + 1;
    assert ((obs - exp <= tol) && (exp - obs <= tol))
      else begin
        errors = errors + 1;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  function automatic int cnt_of(input int which);
    case (which)
      0:       return ocnt_f;
      1:       return ocnt_i;
      2:       return ocnt_s;
      3:       return ptr_f;
      default: return (st_f == 5'd3) ? 1 : 0;
    endcase
  endfunction

  task automatic wait_for(input int which, input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (cnt_of(which) < n && t < budget) begin
      @(negedge clk);
      #1;
      t = t + 1;
    end
    chk(tag, longint'(cnt_of(which) >= n), 1, 0);
  endtask

  task automatic pulse_start(input int which);
    @(posedge clk);
    #1;
    case (which)
      0: start_f = 1'b1;
      1: start_i_tb = 1'b1;
      default: start_s = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start_f = 1'b0;
    start_i_tb = 1'b0;
    start_s = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reading", reading_f, 0, 0);
    chk("rst_done", done_f, 0, 0);
    chk("rst_dout", dout_f, 0, 0);
    chk("rst_state", st_f, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Forward DCT of a flat block of 100: DC 800, all AC zero
    for (int k = 0; k < 64; k++) src_f[k] = 32'd100;
    ptr_f = 0; ocnt_f = 0;
    pulse_start(0);
    wait_for(0, 64, 3000, "t1_wait");
    repeat (4) @(negedge clk);
    #1;
    chk("t1_done_cycles", ocnt_f, 64, 0);
    chk("t1_read_cycles", ptr_f, 64, 0);
    chk("t1_latency", done_cyc_f[0] - read_cyc_f[63], 1025, 0);
    chk("t1_done_contig", done_cyc_f[63] - done_cyc_f[0], 63, 0);
    chk("t1_done_low", done_f, 0, 0);
    chk("t1_dc", $signed(out_f[0][31:16]), 800, 1);
    for (int k = 1; k < 64; k++) chk($sformatf("t1_ac[%0d]", k), $signed(out_f[k][31:16]), 0, 1);

    // Inverse DCT of a lone DC of 800: flat 100
    for (int k = 0; k < 64; k++) src_i[k] = (k == 0) ? 32'd800 : 32'd0;
    ptr_i = 0; ocnt_i = 0;
    pulse_start(1);
    wait_for(1, 64, 3000, "t2_wait");
    for (int k = 0; k < 64; k++) chk($sformatf("t2_pix[%0d]", k), $signed(out_i[k][31:10]), 100, 1);

    // Forward chained into inverse: ramp reconstructs
    for (int k = 0; k < 64; k++) src_f[k] = k;
    chain = 1'b1;
    ptr_f = 0; ocnt_f = 0; ocnt_i = 0;
    pulse_start(0);
    wait_for(1, 64, 4000, "t3_wait");
    chain = 1'b0;
    for (int k = 0; k < 64; k++) chk($sformatf("t3_ramp[%0d]", k), $signed(out_i[k][31:10]), k, 2);

    // start held high: two blocks back-to-back (flat 100, then flat 50)
    for (int k = 0; k < 128; k++) src_f[k] = (k < 64) ? 32'd100 : 32'd50;
    ptr_f = 0; ocnt_f = 0;
    @(posedge clk);
    #1 start_f = 1'b1;
    wait_for(3, 65, 3000, "t4_second_load");
    @(posedge clk);
    #1 start_f = 1'b0;
    wait_for(0, 128, 3000, "t4_wait");
    repeat (4) @(negedge clk);
    #1;
    chk("t4_gap", read_cyc_f[64] - done_cyc_f[63], 1, 0);
    chk("t4_reads", ptr_f, 128, 0);
    chk("t4_outs", ocnt_f, 128, 0);
    chk("t4_dc_a", $signed(out_f[0][31:16]), 800, 1);
    chk("t4_ac_a", $signed(out_f[63][31:16]), 0, 1);
    chk("t4_dc_b", $signed(out_f[64][31:16]), 400, 1);
    chk("t4_ac_b", $signed(out_f[65][31:16]), 0, 1);
    chk("t4_ac_b_last", $signed(out_f[127][31:16]), 0, 1);

    // Reset during the column pass aborts the block
    for (int k = 0; k < 64; k++) src_f[k] = 32'd100;
    ptr_f = 0; ocnt_f = 0;
    pulse_start(0);
    wait_for(4, 1, 2000, "t5_reach_col");
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_reading", reading_f, 0, 0);
    chk("t5_done", done_f, 0, 0);
    chk("t5_dout", dout_f, 0, 0);
    chk("t5_state", st_f, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_f = 0; ocnt_f = 0;
    pulse_start(0);
    wait_for(0, 64, 3000, "t5_wait");
    repeat (4) @(negedge clk);
    #1;
    chk("t5_outs", ocnt_f, 64, 0);
    chk("t5_dc", $signed(out_f[0][31:16]), 800, 1);
    for (int k = 1; k < 64; k++) chk($sformatf("t5_ac[%0d]", k), $signed(out_f[k][31:16]), 0, 1);

    // Full-scale positive input saturates DC instead of wrapping
    ocnt_s = 0;
    pulse_start(2);
    wait_for(2, 64, 3000, "t6_wait");
    chk("t6_sat_dc", out_s0, 64'h7FFF_FFFF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
